ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-port arbiter and command sequencer in front of the SPI-slave RAM. It accepts word-level read/write requests from two requesters, usually the SPI slave path on port 0 and a debug/host port on port 1. Each request becomes the RAM's two-phase command sequence on `din`/`rx_valid`: address phase, then data phase. For reads, it collects the result from `dout`/`tx_valid` and returns it to the requester that issued the read.

## Interface
- `ADDR_SIZE`, 8, address and data word width; the RAM `din` is `ADDR_SIZE+2` bits.
- `RD_TIMEOUT`, 4, number of cycles spent in RWAIT without `ram_tx_valid` before an error response; must be ≥ 2.
- Reset `rst_n`, synchronous, active-low; clock `clk`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `req_valid` in 2: request valid, bit i = port i.
- `req_ready` out 2: request accepted this cycle when `req_valid[i] && req_ready[i]`.
- `req_we` in 2: 1 = write, 0 = read.
- `req_addr` in 2·ADDR_SIZE: port i uses slice [i·ADDR_SIZE +: ADDR_SIZE].
- `req_wdata` in 2·ADDR_SIZE: write data, same slicing as `req_addr`.
- `rsp_valid` out 2: one-cycle read-response pulse, one-hot, to the requesting port.
- `rsp_data` out ADDR_SIZE: read data, valid with `rsp_valid`.
- `rsp_err` out 1: timeout flag, valid with `rsp_valid`.
- `ram_din` out ADDR_SIZE+2: {opcode[1:0], payload}.
- `ram_rx_valid` out 1: command strobe to the RAM.
- `ram_dout` in ADDR_SIZE: RAM read data.
- `ram_tx_valid` in 1: RAM read-data valid.

## Operation
- Opcodes: WRITE_ADD=00, WRITE_DATA=01, READ_ADD=10, READ_DATA=11.
- FSM states: IDLE, WADDR, WDATA, RADDR, RDATA, RWAIT, RESP.
- IDLE:
  - `req_ready` is asserted combinationally, for the granted port only.
  - Grant is round-robin. If only one port is valid, it wins. If both are valid, the port ≠ `last_grant` wins.
  - On accept, latch we/addr/wdata/port and update `last_grant`.
  - Next state is WADDR if the request is a write, RADDR if it is a read.
- WADDR: `ram_din`={00,addr}, `ram_rx_valid`=1; → WDATA.
- WDATA: `ram_din`={01,wdata}, `ram_rx_valid`=1; → IDLE. Writes produce no response.
- RADDR: `ram_din`={10,addr}, `ram_rx_valid`=1; → RDATA.
- RDATA: `ram_din`={11,0}, `ram_rx_valid`=1; → RWAIT; the timeout counter is cleared.
- RWAIT: `ram_rx_valid`=0.
  - On `ram_tx_valid`=1: register `ram_dout` and set err=0; → RESP.
  - When the counter reaches `RD_TIMEOUT`: set data=0, err=1; → RESP.
  - Otherwise the counter increments.
- RESP: `rsp_valid[port]`=1 with registered `rsp_data`/`rsp_err`; → IDLE.
- `ram_tx_valid` seen outside RWAIT is ignored.
- In every state other than the command states above, `ram_rx_valid`=0 and `ram_din`=0.
- Reset (any state, including mid-read): next state is IDLE. `last_grant`=1, so port 0 wins the first tie.
  - The in-flight request is dropped with no response.
  - All registered outputs go to 0: `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `ram_rx_valid`=0, `ram_din`=0.

## Timing
- A request accepted in cycle 0 is handled as follows:
  - Write: WRITE_ADD in cycle 1, WRITE_DATA in cycle 2, next accept possible in cycle 3.
  - Read: READ_ADD in cycle 1, READ_DATA in cycle 2, RAM `tx_valid` expected in cycle 3, `rsp_valid` in cycle 4, next accept possible in cycle 5.
  - Read timeout: `rsp_valid` with `rsp_err`=1 in cycle 3+`RD_TIMEOUT`+1.
- `req_ready` is 0 in every non-IDLE state, so at most one request is in flight.
- A requester may hold `req_valid` across arbitration; its request is not consumed until `req_ready` is asserted.
- `ram_din`/`ram_rx_valid` are registered outputs driven from the state, so they change only on `clk`.

## Configuration
- Macro: `RAM_ARB_ADDR_SKIP_EN`.
- Defined:
  - Track the last issued write address and last issued read address, each with a valid bit. The valid bits are cleared by reset.
  - A write whose address equals the tracked write address goes IDLE→WDATA, skipping WADDR; latency is reduced by 1 cycle.
  - A read whose address equals the tracked read address goes IDLE→RDATA, skipping RADDR.
  - The tracked address is updated whenever an address phase is issued.
- Undefined: every request always issues both phases; there is no tracking logic.

## Structure
- `RAM_shared_pkg` holds:
  - the existing `ADDR_SIZE`/opcode constants (WRITE_ADD, WRITE_DATA, READ_ADD, READ_DATA);
  - new typedef `arb_state_e` (the seven FSM states).
- Sub-module `rr_arbiter_2`: 2-way round-robin grant from `req_valid`, `last_grant` and an accept strobe, producing a one-hot grant.
- The FSM, timeout counter and (optional) address tracking live in `ram_port_arbiter`.

## Test plan
- Port 0 writes addr 0x12 data 0xA5, then reads 0x12 → `ram_din` sequence 0x012, 0x1A5, 0x212, 0x300; `rsp_valid`=01, `rsp_data`=0xA5, `rsp_err`=0 in cycle 4 after the read accept.
- Both ports request reads in the same cycle, held for 4 transactions → grants alternate port 0, 1, 0, 1; each `rsp_valid` goes only to its issuing port.
- RAM model never asserts `tx_valid` on a read, `RD_TIMEOUT`=4 → `rsp_err`=1, `rsp_data`=0 in cycle 8 after accept; the arbiter returns to IDLE and accepts the next request.
- Assert `rst_n`=0 in cycle 2 of a read (RDATA) → the next cycle shows IDLE, `ram_rx_valid`=0 and no `rsp_valid`; the first request after reset is granted normally.
- With `RAM_ARB_ADDR_SKIP_EN`: two writes to 0x40 back-to-back → the second issues only 0x1xx (no 0x040), 1-cycle latency; after reset, a write to 0x40 issues both phases again.

Source files
------------

// File: rtl/RAM_shared_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : RAM_shared_pkg                                             |
// | Description : Shared constants for the SPI-slave RAM and its front-end   |
// |               arbiter: word width, RAM command opcodes and the arbiter  |
// |               FSM state type.                                            |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package RAM_shared_pkg;

  localparam int ADDR_SIZE = 8;

  // Two-bit opcode carried in the top bits of the RAM din word.
  localparam logic [1:0] WRITE_ADD  = 2'b00;
  localparam logic [1:0] WRITE_DATA = 2'b01;
  localparam logic [1:0] READ_ADD   = 2'b10;
  localparam logic [1:0] READ_DATA  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WDATA = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RWAIT = 3'd5,
    RESP  = 3'd6
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arbiter_2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter_2                                               |
// | Description : Two-way round-robin arbiter. A lone requester always wins; |
// |               on a tie the port that did not win last time is granted.   |
// |               The winner is remembered whenever accept is strobed.       |
// | Ports       : clk, rst_n      - clock, synchronous active-low reset      |
// |               req_valid[1:0]  - request per port                         |
// |               accept          - the current grant was consumed           |
// |               grant[1:0]      - one-hot grant (zero when no request)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic r_last_grant;

  // Port 0 wins alone, or on a tie when port 1 was the previous winner.
  assign grant[0] = req_valid[0] & (~req_valid[1] |  r_last_grant);
  assign grant[1] = req_valid[1] & (~req_valid[0] | ~r_last_grant);

  // Reset to port 1 so that port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (accept) begin
      r_last_grant <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_port_arbiter                                           |
// | Description : Two-port arbiter and command sequencer for the SPI-slave   |
// |               RAM. Each accepted request is turned into an address phase |
// |               and a data phase on ram_din/ram_rx_valid; read data coming |
// |               back on ram_dout/ram_tx_valid is returned to the issuing   |
// |               port, or an error response is produced after RD_TIMEOUT.   |
// | Options     : RAM_ARB_ADDR_SKIP_EN - skip the address phase when the     |
// |               address matches the last one issued for that direction.    |
// | Ports       : clk, rst_n           - clock, synchronous active-low reset |
// |               req_valid/ready/we   - per-port request handshake          |
// |               req_addr/req_wdata   - packed per-port address / wdata     |
// |               rsp_valid/data/err   - one-cycle read response             |
// |               ram_din/ram_rx_valid - registered command to the RAM       |
// |               ram_dout/ram_tx_valid- read data from the RAM              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ram_port_arbiter #(
  parameter int ADDR_SIZE  = RAM_shared_pkg::ADDR_SIZE,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [2*ADDR_SIZE-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [ADDR_SIZE-1:0]   rsp_data,
  output logic                   rsp_err,
  output logic [ADDR_SIZE+1:0]   ram_din,
  output logic                   ram_rx_valid,
  input  logic [ADDR_SIZE-1:0]   ram_dout,
  input  logic                   ram_tx_valid
);

  import RAM_shared_pkg::*;

  localparam int              CNT_W     = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(RD_TIMEOUT);

  arb_state_e               r_state;
  arb_state_e               w_next;
  logic [1:0]               w_grant;
  logic                     w_accept;
  logic                     w_sel_port;
  logic                     w_sel_we;
  logic [ADDR_SIZE-1:0]     w_sel_addr;
  logic [ADDR_SIZE-1:0]     w_sel_wdata;
  logic [ADDR_SIZE-1:0]     w_cmd_addr;
  logic [ADDR_SIZE-1:0]     w_cmd_wdata;
  logic [ADDR_SIZE+1:0]     w_din;
  logic                     w_rx_valid;
  logic                     w_skip_w;
  logic                     w_skip_r;
  logic                     w_timeout;

  logic                     r_port;
  logic [ADDR_SIZE-1:0]     r_addr;
  logic [ADDR_SIZE-1:0]     r_wdata;
  logic [CNT_W-1:0]         r_cnt;
  logic [1:0]               r_rsp_valid;
  logic [ADDR_SIZE-1:0]     r_rsp_data;
  logic                     r_rsp_err;
  logic [ADDR_SIZE+1:0]     r_ram_din;
  logic                     r_ram_rx_valid;

  rr_arbiter_2 u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .accept    (w_accept),
    .grant     (w_grant)
  );

  assign req_ready   = (r_state == IDLE) ? w_grant : 2'b00;
  assign w_accept    = |(req_valid & req_ready);
  assign w_sel_port  = w_grant[1];
  assign w_sel_we    = w_sel_port ? req_we[1] : req_we[0];
  assign w_sel_addr  = w_sel_port ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE]  : req_addr[ADDR_SIZE-1:0];
  assign w_sel_wdata = w_sel_port ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE] : req_wdata[ADDR_SIZE-1:0];
  assign w_timeout   = (r_cnt == C_TIMEOUT);

`ifdef RAM_ARB_ADDR_SKIP_EN
  logic                 r_wa_valid;
  logic                 r_ra_valid;
  logic [ADDR_SIZE-1:0] r_wa;
  logic [ADDR_SIZE-1:0] r_ra;

  // Remember the address the RAM currently holds for each direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wa_valid <= 1'b0;
      r_ra_valid <= 1'b0;
      r_wa       <= '0;
      r_ra       <= '0;
    end else begin
      if (r_state == WADDR) begin
        r_wa_valid <= 1'b1;
        r_wa       <= r_addr;
      end
      if (r_state == RADDR) begin
        r_ra_valid <= 1'b1;
        r_ra       <= r_addr;
      end
    end
  end

  assign w_skip_w = r_wa_valid && (r_wa == w_sel_addr);
  assign w_skip_r = r_ra_valid && (r_ra == w_sel_addr);
`else
  assign w_skip_w = 1'b0;
  assign w_skip_r = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_sel_we) w_next = w_skip_w ? WDATA : WADDR;
          else          w_next = w_skip_r ? RDATA : RADDR;
        end
      end
      WADDR:   w_next = WDATA;
      WDATA:   w_next = IDLE;
      RADDR:   w_next = RDATA;
      RDATA:   w_next = RWAIT;
      RWAIT:   if (ram_tx_valid || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command payload: in IDLE the request is only being accepted now, so
  // take it straight from the selected port rather than the latch.
  assign w_cmd_addr  = (r_state == IDLE) ? w_sel_addr  : r_addr;
  assign w_cmd_wdata = (r_state == IDLE) ? w_sel_wdata : r_wdata;

  // Output logic, decoded from the next state so the registered command
  // appears in the same cycle the FSM enters the command state.
  always_comb begin
    w_din      = '0;
    w_rx_valid = 1'b0;
    case (w_next)
      WADDR: begin
        w_din      = {WRITE_ADD, w_cmd_addr};
        w_rx_valid = 1'b1;
      end
      WDATA: begin
        w_din      = {WRITE_DATA, w_cmd_wdata};
        w_rx_valid = 1'b1;
      end
      RADDR: begin
        w_din      = {READ_ADD, w_cmd_addr};
        w_rx_valid = 1'b1;
      end
      RDATA: begin
        w_din      = {READ_DATA, {ADDR_SIZE{1'b0}}};
        w_rx_valid = 1'b1;
      end
      default: begin
        w_din      = '0;
        w_rx_valid = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_port         <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_cnt          <= '0;
      r_rsp_valid    <= 2'b00;
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
      r_ram_din      <= '0;
      r_ram_rx_valid <= 1'b0;
    end else begin
      r_ram_din      <= w_din;
      r_ram_rx_valid <= w_rx_valid;

      if (w_accept) begin
        r_port  <= w_sel_port;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end

      if (r_state == RDATA) begin
        r_cnt <= '0;
      end else if (r_state == RWAIT && !ram_tx_valid && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Real data takes priority over a timeout landing in the same cycle.
      if (r_state == RWAIT) begin
        if (ram_tx_valid) begin
          r_rsp_data <= ram_dout;
          r_rsp_err  <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end
      end

      r_rsp_valid <= (w_next == RESP) ? (r_port ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;
  assign ram_din      = r_ram_din;
  assign ram_rx_valid = r_ram_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ram_port_arbiter                                        |
// | Description : Self-checking bench for ram_port_arbiter. A transaction-   |
// |               level model predicts grants, RAM command words, response   |
// |               latency, data and timeout errors. Honours                 |
// |               RAM_ARB_ADDR_SKIP_EN when the macro is defined.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ram_port_arbiter;

  localparam int AW = 8;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*AW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [AW-1:0]   rsp_data;
  logic            rsp_err;
  logic [AW+1:0]   ram_din;
  logic            ram_rx_valid;
  logic [AW-1:0]   ram_dout;
  logic            ram_tx_valid;

  ram_port_arbiter #(.ADDR_SIZE(AW), .RD_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] mem [256];
  bit            pend    [2];
  bit            p_we    [2];
  logic [AW-1:0] p_addr  [2];
  logic [AW-1:0] p_wdata [2];
  int            last_grant;
`ifdef RAM_ARB_ADDR_SKIP_EN
  bit            wa_v, ra_v;
  logic [AW-1:0] wa, ra;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    req_valid = {pend[1], pend[0]};
    req_we    = {p_we[1], p_we[0]};
    req_addr  = {p_addr[1], p_addr[0]};
    req_wdata = {p_wdata[1], p_wdata[0]};
  endtask

  // RAM read-valid chatter that the arbiter must ignore outside RWAIT.
  task automatic noise();
    ram_tx_valid = 1'($urandom_range(0, 1));
    ram_dout     = 8'($urandom);
  endtask

  task automatic set_req(input int p, input bit we, input logic [AW-1:0] a, input logic [AW-1:0] d);
    pend[p]    = 1'b1;
    p_we[p]    = we;
    p_addr[p]  = a;
    p_wdata[p] = d;
  endtask

  task automatic model_reset();
    last_grant = 1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
`ifdef RAM_ARB_ADDR_SKIP_EN
    wa_v = 1'b0;
    ra_v = 1'b0;
`endif
  endtask

  // Round robin: a lone requester wins, a tie goes away from the last winner.
  function automatic int pick();
    if (pend[0] && pend[1]) return (last_grant == 0) ? 1 : 0;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive_reqs();
    ram_tx_valid = 1'b0;
    tick();
    tick();
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_data", rsp_data, 8'h00);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_rx_valid", ram_rx_valid, 1'b0);
    check("reset_din", ram_din, 10'h000);
    rst_n = 1'b1;
  endtask

  // One full transaction for whichever port the model says wins now.
  // d = RWAIT cycle in which the RAM answers a read, -1 = never.
  task automatic serve(input int d);
    int            w;
    bit            we;
    bit            skip;
    bit            hit;
    int            last;
    logic [AW-1:0] a, wd, exp_data;
    logic [AW+1:0] cmds[$];

    drive_reqs();
    noise();
    #1;
    w = pick();
    check("accept_ready", req_ready, (w == 1) ? 2'b10 : 2'b01);
    we = p_we[w];
    a  = p_addr[w];
    wd = p_wdata[w];
    skip = 1'b0;
`ifdef RAM_ARB_ADDR_SKIP_EN
    skip = we ? (wa_v && wa == a) : (ra_v && ra == a);
    if (we) begin wa_v = 1'b1; wa = a; end
    else    begin ra_v = 1'b1; ra = a; end
`endif
    if (we) begin
      if (!skip) cmds.push_back({2'b00, a});
      cmds.push_back({2'b01, wd});
    end else begin
      if (!skip) cmds.push_back({2'b10, a});
      cmds.push_back({2'b11, 8'h00});
    end
    last_grant = w;
    pend[w]    = 1'b0;

    for (int i = 0; i < cmds.size(); i++) begin
      tick();
      drive_reqs();
      noise();
      #1;
      check("cmd_din", ram_din, cmds[i]);
      check("cmd_rx_valid", ram_rx_valid, 1'b1);
      check("cmd_busy_ready", req_ready, 2'b00);
      check("cmd_rsp_valid", rsp_valid, 2'b00);
    end

    if (we) begin
      mem[a] = wd;
      tick();
      drive_reqs();
      noise();
      #1;
      check("wr_end_rx_valid", ram_rx_valid, 1'b0);
      check("wr_end_din", ram_din, 10'h000);
      check("wr_end_rsp_valid", rsp_valid, 2'b00);
    end else begin
      hit      = (d >= 0) && (d <= TO);
      exp_data = hit ? mem[a] : 8'h00;
      last     = hit ? d : TO;
      for (int k = 0; k <= last; k++) begin
        tick();
        drive_reqs();
        if (k == d) begin
          ram_tx_valid = 1'b1;
          ram_dout     = mem[a];
        end else begin
          ram_tx_valid = 1'b0;
          ram_dout     = 8'($urandom);
        end
        #1;
        check("wait_rx_valid", ram_rx_valid, 1'b0);
        check("wait_rsp_valid", rsp_valid, 2'b00);
        check("wait_busy_ready", req_ready, 2'b00);
      end
      tick();
      drive_reqs();
      noise();
      #1;
      check("rsp_valid", rsp_valid, (w == 1) ? 2'b10 : 2'b01);
      check("rsp_data", rsp_data, exp_data);
      check("rsp_err", rsp_err, hit ? 1'b0 : 1'b1);
      check("rsp_rx_valid", ram_rx_valid, 1'b0);
      tick();
      drive_reqs();
      noise();
      #1;
      check("post_rsp_valid", rsp_valid, 2'b00);
    end
  endtask

  initial begin
    int w;
    int dd;
    rst_n        = 1'b0;
    req_valid    = 2'b00;
    req_we       = 2'b00;
    req_addr     = '0;
    req_wdata    = '0;
    ram_dout     = '0;
    ram_tx_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    do_reset();

    // Port 0 write then read back.
    set_req(0, 1'b1, 8'h12, 8'hA5);
    serve(0);
    set_req(0, 1'b0, 8'h12, 8'h00);
    serve(0);

    // Both ports hold reads: grants must alternate starting at port 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) set_req(0, 1'b0, 8'($urandom_range(0, 15)), 8'h00);
      if (!pend[1]) set_req(1, 1'b0, 8'($urandom_range(0, 15)), 8'h00);
      serve(int'($urandom_range(0, TO)));
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Timeout, then a normal accept, then data on the final wait cycle.
    set_req(1, 1'b0, 8'h5A, 8'h00);
    serve(-1);
    set_req(0, 1'b1, 8'h5A, 8'h3C);
    serve(0);
    set_req(1, 1'b0, 8'h5A, 8'h00);
    serve(TO);

    // Reset during the READ_DATA cycle drops the read.
    do_reset();
    set_req(0, 1'b0, 8'h33, 8'h00);
    drive_reqs();
    #1;
    check("mid_accept_ready", req_ready, 2'b01);
    last_grant = 0;
    pend[0]    = 1'b0;
    tick();
    drive_reqs();
    #1;
    check("mid_raddr_din", ram_din, 10'h233);
    tick();
    #1;
    check("mid_rdata_din", ram_din, 10'h300);
    rst_n = 1'b0;
    model_reset();
    drive_reqs();
    ram_tx_valid = 1'b1;
    ram_dout     = 8'h77;
    tick();
    rst_n        = 1'b1;
    ram_tx_valid = 1'b0;
    check("mid_reset_rx_valid", ram_rx_valid, 1'b0);
    check("mid_reset_din", ram_din, 10'h000);
    check("mid_reset_rsp_valid", rsp_valid, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_reset_no_rsp", rsp_valid, 2'b00);
    end
    set_req(0, 1'b1, 8'h21, 8'h9E);
    set_req(1, 1'b1, 8'h22, 8'h9F);
    serve(0);
    serve(0);

    // Back-to-back writes to the same address, then again after reset.
    set_req(0, 1'b1, 8'h40, 8'h11);
    serve(0);
    set_req(0, 1'b1, 8'h40, 8'h22);
    serve(0);
    do_reset();
    set_req(0, 1'b1, 8'h40, 8'h33);
    serve(0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0)
          set_req(p, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 8'h40 : 8'($urandom_range(0, 15)),
                  8'($urandom));
      end
      if (pend[0] || pend[1]) begin
        dd = int'($urandom_range(0, TO + 1));
        serve((dd == TO + 1) ? -1 : dd);
      end else begin
        tick();
        drive_reqs();
        noise();
        #1;
        check("idle_rsp_valid", rsp_valid, 2'b00);
        check("idle_rx_valid", ram_rx_valid, 1'b0);
      end
    end

    w = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors + w);
    $finish;
  end

endmodule
`default_nettype wire
